// File: rtl/operand_fetch_pkg.sv
// Shared constants for the operand fetch stage: datapath width, register
// address width and architectural register count.
package operand_fetch_pkg;

    localparam int OF_XLEN     = 32;
    localparam int OF_RA_W     = 5;
    localparam int OF_NUM_REGS = 1 << OF_RA_W;

    // Index of the hardwired-zero register.
    localparam int OF_ZERO_REG = 0;

endpackage

// File: rtl/operand_bypass.sv
// Source operand resolution for one register read port.
// Build option: OPERAND_FETCH_FWD_EN enables the EX/MEM/WB forwarding paths.
// Without it, any in-flight writer of the source register causes a stall and
// the operand always comes from the register file.
module operand_bypass
    import operand_fetch_pkg::*;
#(
    parameter int XLEN = OF_XLEN,
    parameter int RA_W = OF_RA_W
) (
    input  logic            used,
    input  logic [RA_W-1:0] rs,
    input  logic [XLEN-1:0] rf_data,
    input  logic            ex_we,
    input  logic [RA_W-1:0] ex_rd,
    input  logic [XLEN-1:0] ex_data,
    input  logic            ex_is_load,
    input  logic            mem_we,
    input  logic [RA_W-1:0] mem_rd,
    input  logic [XLEN-1:0] mem_data,
    input  logic            wb_we,
    input  logic [RA_W-1:0] wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic [XLEN-1:0] data,
    output logic            hazard
);

    logic rs_zero;
    logic ex_hit;
    logic mem_hit;
    logic wb_hit;

    assign rs_zero = (rs == RA_W'(OF_ZERO_REG));
    assign ex_hit  = ex_we  && (ex_rd  == rs) && !rs_zero;
    assign mem_hit = mem_we && (mem_rd == rs) && !rs_zero;
    assign wb_hit  = wb_we  && (wb_rd  == rs) && !rs_zero;

`ifdef OPERAND_FETCH_FWD_EN

    // Youngest matching producer wins; a load in EX has no data yet.
    always_comb begin
        data = rf_data;
        if (rs_zero) begin
            data = '0;
        end else if (ex_hit && !ex_is_load) begin
            data = ex_data;
        end else if (mem_hit) begin
            data = mem_data;
        end else if (wb_hit) begin
            data = wb_data;
        end
    end

    // Only a load still in EX cannot be bypassed.
    assign hazard = used && ex_hit && ex_is_load;

`else

    logic unused_fwd;
    assign unused_fwd = ^{ex_data, mem_data, wb_data, ex_is_load};

    // No bypass network: x0 reads zero, everything else from the register file.
    always_comb begin
        data = rf_data;
        if (rs_zero) begin
            data = '0;
        end
    end

    // Any pending writer of this register must retire before we read it.
    assign hazard = used && (ex_hit || mem_hit || wb_hit);

`endif

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch stage: reads the register file, resolves both source
// operands (with optional forwarding), detects read-after-write hazards and
// holds the result in a single output register.
// Build option: OPERAND_FETCH_FWD_EN (see operand_bypass).
//
// Handshake: a transfer happens on a rising clk edge when valid && ready are
// both high on that interface. A producer holding valid keeps its payload
// stable until ready; ready may depend combinationally on the consumer's ready.
module operand_fetch
    import operand_fetch_pkg::*;
#(
    parameter int XLEN = OF_XLEN,
    parameter int RA_W = OF_RA_W
) (
    input  logic            clk,
    input  logic            rst,
    // upstream
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [RA_W-1:0] in_rs1,
    input  logic [RA_W-1:0] in_rs2,
    input  logic [RA_W-1:0] in_rd,
    input  logic            in_rs1_used,
    input  logic            in_rs2_used,
    input  logic            in_rd_we,
    input  logic [XLEN-1:0] in_imm,
    input  logic [XLEN-1:0] in_pc,
    // register file
    output logic [RA_W-1:0] rf_addr1,
    output logic [RA_W-1:0] rf_addr2,
    input  logic [XLEN-1:0] rf_data1,
    input  logic [XLEN-1:0] rf_data2,
    // bypass sources
    input  logic            ex_we,
    input  logic [RA_W-1:0] ex_rd,
    input  logic [XLEN-1:0] ex_data,
    input  logic            ex_is_load,
    input  logic            mem_we,
    input  logic [RA_W-1:0] mem_rd,
    input  logic [XLEN-1:0] mem_data,
    input  logic            wb_we,
    input  logic [RA_W-1:0] wb_rd,
    input  logic [XLEN-1:0] wb_data,
    // pipeline control
    input  logic            flush,
    // downstream
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_op1,
    output logic [XLEN-1:0] out_op2,
    output logic [XLEN-1:0] out_imm,
    output logic [XLEN-1:0] out_pc,
    output logic [RA_W-1:0] out_rd,
    output logic            out_rd_we,
    // statistics
    output logic [31:0]     stall_cnt
);

    logic [XLEN-1:0] op1_res;
    logic [XLEN-1:0] op2_res;
    logic            hazard1;
    logic            hazard2;
    logic            hazard;
    logic            capture;

    assign rf_addr1 = in_rs1;
    assign rf_addr2 = in_rs2;

    operand_bypass #(
        .XLEN (XLEN),
        .RA_W (RA_W)
    ) u_bypass_rs1 (
        .used       (in_rs1_used),
        .rs         (in_rs1),
        .rf_data    (rf_data1),
        .ex_we      (ex_we),
        .ex_rd      (ex_rd),
        .ex_data    (ex_data),
        .ex_is_load (ex_is_load),
        .mem_we     (mem_we),
        .mem_rd     (mem_rd),
        .mem_data   (mem_data),
        .wb_we      (wb_we),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .data       (op1_res),
        .hazard     (hazard1)
    );

    operand_bypass #(
        .XLEN (XLEN),
        .RA_W (RA_W)
    ) u_bypass_rs2 (
        .used       (in_rs2_used),
        .rs         (in_rs2),
        .rf_data    (rf_data2),
        .ex_we      (ex_we),
        .ex_rd      (ex_rd),
        .ex_data    (ex_data),
        .ex_is_load (ex_is_load),
        .mem_we     (mem_we),
        .mem_rd     (mem_rd),
        .mem_data   (mem_data),
        .wb_we      (wb_we),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .data       (op2_res),
        .hazard     (hazard2)
    );

    assign hazard   = hazard1 || hazard2;
    // Reset is asynchronous, so ready is also gated directly by rst.
    assign in_ready = !rst && !hazard && !flush && (!out_valid || out_ready);
    assign capture  = in_valid && in_ready;

    // Output register: flush drops the held entry, a capture loads a new one,
    // a consumed entry with nothing behind it leaves a bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_op1   <= '0;
            out_op2   <= '0;
            out_imm   <= '0;
            out_pc    <= '0;
            out_rd    <= '0;
            out_rd_we <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (capture) begin
            out_valid <= 1'b1;
            out_op1   <= op1_res;
            out_op2   <= op2_res;
            out_imm   <= in_imm;
            out_pc    <= in_pc;
            out_rd    <= in_rd;
            out_rd_we <= in_rd_we;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Count cycles where an offered instruction was held back (free-running wrap).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (in_valid && !in_ready && !flush) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_operand_fetch.sv
// Self-checking bench for operand_fetch: directed scenarios plus randomized
// traffic against a queue-based reference model. Honors OPERAND_FETCH_FWD_EN.
module tb_operand_fetch;
  localparam int XLEN = 32;
  localparam int RA_W = 5;
  // txn = {op1, op2, imm, pc, rd, rd_we, chk_op1, chk_op2}
  localparam int TW = 4*XLEN + RA_W + 3;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [RA_W-1:0] in_rs1, in_rs2, in_rd;
  logic            in_rs1_used, in_rs2_used, in_rd_we;
  logic [XLEN-1:0] in_imm, in_pc;
  logic [RA_W-1:0] rf_addr1, rf_addr2;
  logic [XLEN-1:0] rf_data1, rf_data2;
  logic            ex_we, mem_we, wb_we, ex_is_load;
  logic [RA_W-1:0] ex_rd, mem_rd, wb_rd;
  logic [XLEN-1:0] ex_data, mem_data, wb_data;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_op1, out_op2, out_imm, out_pc;
  logic [RA_W-1:0] out_rd;
  logic            out_rd_we;
  logic [31:0]     stall_cnt;

  int n_checks = 0;
  int n_pass   = 0;
  logic [TW-1:0] exp_q[$];
  logic [31:0]   exp_stall;

  operand_fetch dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .in_rs1_used(in_rs1_used), .in_rs2_used(in_rs2_used), .in_rd_we(in_rd_we),
    .in_imm(in_imm), .in_pc(in_pc),
    .rf_addr1(rf_addr1), .rf_addr2(rf_addr2),
    .rf_data1(rf_data1), .rf_data2(rf_data2),
    .ex_we(ex_we), .ex_rd(ex_rd), .ex_data(ex_data), .ex_is_load(ex_is_load),
    .mem_we(mem_we), .mem_rd(mem_rd), .mem_data(mem_data),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_op1(out_op1), .out_op2(out_op2), .out_imm(out_imm), .out_pc(out_pc),
    .out_rd(out_rd), .out_rd_we(out_rd_we),
    .stall_cnt(stall_cnt)
  );

  // clock / reset block
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
  endtask

  // ---------------- reference model ----------------
  // Producers listed youngest first; first matching usable producer supplies the value.
  function automatic logic [XLEN-1:0] ref_operand(input logic [RA_W-1:0] rs, input logic [XLEN-1:0] rf);
    logic            we[3];
    logic [RA_W-1:0] rd[3];
    logic [XLEN-1:0] d[3];
    logic            usable[3];
    we = '{ex_we, mem_we, wb_we};
    rd = '{ex_rd, mem_rd, wb_rd};
    d  = '{ex_data, mem_data, wb_data};
    usable = '{!ex_is_load, 1'b1, 1'b1};
    if (rs == 0) return '0;
`ifdef OPERAND_FETCH_FWD_EN
    for (int i = 0; i < 3; i++)
      if (we[i] && rd[i] == rs) return usable[i] ? d[i] : rf;
`endif
    return rf;
  endfunction

  function automatic logic ref_blocked(input logic [RA_W-1:0] rs, input logic used);
    int writers;
    if (!used || rs == 0) return 1'b0;
`ifdef OPERAND_FETCH_FWD_EN
    return ex_we && ex_is_load && ex_rd == rs;
`else
    writers = 0;
    if (ex_we  && ex_rd  == rs) writers++;
    if (mem_we && mem_rd == rs) writers++;
    if (wb_we  && wb_rd  == rs) writers++;
    return writers != 0;
`endif
  endfunction

  task automatic check_outputs();
    logic [TW-1:0] t;
    check("out_valid", out_valid, exp_q.size() != 0);
    check("stall_cnt", stall_cnt, exp_stall);
    if (exp_q.size() != 0) begin
      t = exp_q[0];
      if (t[1]) check("out_op1", out_op1, t[TW-1 -: XLEN]);
      if (t[0]) check("out_op2", out_op2, t[TW-XLEN-1 -: XLEN]);
      check("out_imm",   out_imm,   t[TW-2*XLEN-1 -: XLEN]);
      check("out_pc",    out_pc,    t[TW-3*XLEN-1 -: XLEN]);
      check("out_rd",    out_rd,    t[RA_W+2 -: RA_W]);
      check("out_rd_we", out_rd_we, t[2]);
    end
  endtask

  // One clock: check comb outputs for current inputs, advance model, clock, check regs.
  task automatic step();
    logic exp_ready;
    #1;
    exp_ready = !ref_blocked(in_rs1, in_rs1_used) && !ref_blocked(in_rs2, in_rs2_used)
                && !flush && (exp_q.size() == 0 || out_ready);
    check("in_ready", in_ready, exp_ready);
    check("rf_addr1", rf_addr1, in_rs1);
    check("rf_addr2", rf_addr2, in_rs2);
    if (in_valid && !exp_ready && !flush) exp_stall = exp_stall + 32'd1;
    if (flush) exp_q.delete();
    else begin
      if (exp_q.size() != 0 && out_ready) void'(exp_q.pop_front());
      if (in_valid && exp_ready)
        exp_q.push_back({ref_operand(in_rs1, rf_data1), ref_operand(in_rs2, rf_data2),
                         in_imm, in_pc, in_rd, in_rd_we, in_rs1_used, in_rs2_used});
    end
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    in_valid = 0; in_rs1 = 0; in_rs2 = 0; in_rd = 0;
    in_rs1_used = 0; in_rs2_used = 0; in_rd_we = 0;
    in_imm = 0; in_pc = 0; rf_data1 = 0; rf_data2 = 0;
    ex_we = 0; ex_rd = 0; ex_data = 0; ex_is_load = 0;
    mem_we = 0; mem_rd = 0; mem_data = 0;
    wb_we = 0; wb_rd = 0; wb_data = 0;
    flush = 0; out_ready = 1;
  endtask

  task automatic drive_instr(input logic [RA_W-1:0] rs1, input logic u1,
                             input logic [RA_W-1:0] rs2, input logic u2,
                             input logic [XLEN-1:0] pc);
    in_valid = 1; in_rs1 = rs1; in_rs1_used = u1; in_rs2 = rs2; in_rs2_used = u2;
    in_rd = RA_W'($urandom_range(0, 31)); in_rd_we = 1'($urandom_range(0, 1));
    in_imm = $urandom; in_pc = pc;
    rf_data1 = $urandom; rf_data2 = $urandom;
  endtask

  task automatic rand_inputs();
    in_valid = $urandom_range(0, 3) != 0;
    in_rs1 = RA_W'($urandom_range(0, 7)); in_rs2 = RA_W'($urandom_range(0, 7));
    in_rs1_used = 1'($urandom_range(0, 1)); in_rs2_used = 1'($urandom_range(0, 1));
    in_rd = RA_W'($urandom_range(0, 31)); in_rd_we = 1'($urandom_range(0, 1));
    in_imm = $urandom; in_pc = $urandom;
    rf_data1 = $urandom; rf_data2 = $urandom;
    ex_we = 1'($urandom_range(0, 1)); ex_rd = RA_W'($urandom_range(0, 7));
    ex_data = $urandom; ex_is_load = $urandom_range(0, 3) == 0;
    mem_we = 1'($urandom_range(0, 1)); mem_rd = RA_W'($urandom_range(0, 7)); mem_data = $urandom;
    wb_we = 1'($urandom_range(0, 1)); wb_rd = RA_W'($urandom_range(0, 7)); wb_data = $urandom;
    flush = $urandom_range(0, 15) == 0;
    out_ready = $urandom_range(0, 3) != 0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_valid"}, out_valid, 1'b0);
    check({tag, "_ready"}, in_ready, 1'b0);
    check({tag, "_op1"}, out_op1, '0);
    check({tag, "_op2"}, out_op2, '0);
    check({tag, "_imm"}, out_imm, '0);
    check({tag, "_pc"}, out_pc, '0);
    check({tag, "_rd"}, {out_rd, out_rd_we}, '0);
    check({tag, "_stall"}, stall_cnt, '0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    idle_inputs();
    exp_stall = 0;
    rst = 1;
    in_valid = 1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_state("rst");
    in_valid = 0;
    @(negedge clk);
    rst = 0;
    @(posedge clk);
    #1;

    // youngest producer wins; x0 always reads zero
`ifdef OPERAND_FETCH_FWD_EN
    drive_instr(5, 1, 0, 0, 32'h100);
    ex_we = 1; ex_rd = 5; ex_data = 32'h11;
    mem_we = 1; mem_rd = 5; mem_data = 32'h22;
    step();
    check("fwd_ex_prio", out_op1, 32'h11);
    idle_inputs();
`endif
    drive_instr(1, 0, 0, 1, 32'h104);
    wb_we = 1; wb_rd = 0; wb_data = 32'hFF;
    step();
    check("x0_zero", out_op2, 32'h0);
    idle_inputs();
    step();

`ifdef OPERAND_FETCH_FWD_EN
    // load-use stall, then bypass from EX once the load data is ready
    drive_instr(7, 1, 2, 0, 32'h108);
    ex_we = 1; ex_rd = 7; ex_is_load = 1; ex_data = 32'h77;
    step();
    check("load_bubble", out_valid, 1'b0);
    check("load_stall_cnt", stall_cnt, 32'd1);
    ex_is_load = 0;
    step();
    check("load_release", out_valid, 1'b1);
    check("load_release_op1", out_op1, 32'h77);
    idle_inputs();
    step();
`else
    // without bypass, a pending WB writer stalls until it retires
    drive_instr(3, 1, 0, 0, 32'h108);
    rf_data1 = 32'hABCD;
    wb_we = 1; wb_rd = 3; wb_data = 32'h3333;
    repeat (2) begin
      step();
      check("wb_stall_bubble", out_valid, 1'b0);
    end
    check("wb_stall_cnt", stall_cnt, 32'd2);
    wb_we = 0;
    step();
    check("wb_release_op1", out_op1, 32'hABCD);
    idle_inputs();
    step();
`endif

    // back-pressure: held entry stays put while a new one waits
    drive_instr(1, 1, 2, 1, 32'h200);
    step();
    drive_instr(4, 1, 6, 1, 32'h204);
    out_ready = 0;
    repeat (3) begin
      step();
      check("hold_pc", out_pc, 32'h200);
    end
    out_ready = 1;
    step();
    check("hold_release_pc", out_pc, 32'h204);

    // flush kills both held and incoming instruction
    drive_instr(2, 1, 3, 1, 32'h300);
    out_ready = 0;
    flush = 1;
    step();
    check("flush_kill", out_valid, 1'b0);
    idle_inputs();
    step();

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      rand_inputs();
      step();
    end

    // asynchronous reset mid-cycle with traffic in flight
    drive_instr(1, 1, 1, 1, 32'h400);
    step();
    rst = 1;
    #2;
    check_reset_state("async_rst");
    exp_q.delete();
    exp_stall = 0;
    @(negedge clk);
    rst = 0;
    idle_inputs();
    @(posedge clk);
    #1;
    for (int i = 0; i < 50; i++) begin
      rand_inputs();
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/operand_fetch.md
OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning the operand/data width.
REQ-002 SHALL have parameter RA_W, default 5, meaning the register address width.
REQ-003 SHALL have port clk  in  1  clock; all state on rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have upstream ports: in_valid in 1; in_ready out 1; in_rs1, in_rs2, in_rd in RA_W; in_rs1_used, in_rs2_used, in_rd_we in 1; in_imm, in_pc in XLEN.
REQ-006 SHALL have regfile ports: rf_addr1, rf_addr2 out RA_W; rf_data1, rf_data2 in XLEN (combinational read).
REQ-007 SHALL have bypass ports for X in {ex, mem, wb}: X_we in 1; X_rd in RA_W; X_data in XLEN. SHALL also have ex_is_load in 1 (EX result not yet available).
REQ-008 SHALL have port flush  in  1  kills the held and incoming instruction.
REQ-009 SHALL have downstream ports: out_valid in... out_valid out 1; out_ready in 1; out_op1, out_op2, out_imm, out_pc out XLEN; out_rd out RA_W; out_rd_we out 1.
REQ-010 SHALL have port stall_cnt  out 32  count of hazard-stalled cycles.

Function
REQ-011 SHALL drive rf_addr1=in_rs1, rf_addr2=in_rs2 combinationally.
REQ-012 SHALL resolve each used source: x0 -> 0; else EX match (ex_we, ex_rd==rs, !ex_is_load) > MEM match > WB match > rf_data (priority order).
REQ-013 SHALL flag hazard when ex_we && ex_is_load && ex_rd!=0 && ex_rd matches a used source.
REQ-014 SHALL compute in_ready = !hazard && !flush && (!out_valid || out_ready).
REQ-015 SHALL capture resolved operands plus rd/rd_we/imm/pc into the output register on in_valid && in_ready; latency 1 cycle.
REQ-016 SHALL keep out_* stable while out_valid && !out_ready.
REQ-017 SHALL clear out_valid when out_ready && (no capture), including while hazard holds (bubble).
REQ-018 SHALL, on flush, clear out_valid next cycle regardless of out_ready and capture nothing.
REQ-019 SHALL ignore unused sources for hazard and forwarding.
REQ-020 SHALL increment stall_cnt each cycle in_valid && !in_ready && !flush; wraps at 2^32-1 -> 0.

Reset
REQ-021 SHALL on rst clear out_valid, out_rd_we, out_rd, out_op1, out_op2, out_imm, out_pc, stall_cnt to 0 immediately.
REQ-022 SHALL discard any in-flight instruction on rst; in_ready=0 while rst high.

Configuration
REQ-023 SHALL support macro OPERAND_FETCH_FWD_EN.
REQ-024 With OPERAND_FETCH_FWD_EN defined: forwarding per REQ-012/013.
REQ-025 Without it: no forwarding paths; hazard = any EX/MEM/WB we with nonzero rd matching a used source; operands from rf_data only.

Structure
REQ-026 SHALL take XLEN, RA_W and register count from the shared const/inst defines package; no local redefinition.
REQ-027 SHALL place source resolution (REQ-012) in one sub-module, operand_bypass, instantiated twice.

Verification
REQ-028 rs1=5 used, ex_we=1 ex_rd=5 ex_data=0x11, mem_rd=5 data=0x22 -> out_op1=0x11 next cycle.
REQ-029 rs2=0 used, wb_rd=0 wb_data=0xFF -> out_op2=0.
REQ-030 ex_is_load=1 ex_rd=7, in_rs1=7 used -> in_ready=0, out_valid=0 next cycle, stall_cnt +1; load clears -> captured.
REQ-031 out_valid=1, out_ready=0 for 3 cycles -> out_* unchanged, in_ready=0; out_ready=1 -> new capture.
REQ-032 flush with in_valid=1 and out_valid=1 -> out_valid=0 next cycle, nothing captured.
REQ-033 Without OPERAND_FETCH_FWD_EN: wb_we=1 wb_rd=3, rs1=3 used -> stall until wb_we=0, then out_op1=rf_data1.
